// File: rtl/i2c_pkg.sv
// Shared types for the read-only I2C slave: SDA drive select
// and the sequencing FSM state encoding.
package i2c_pkg;

  typedef enum logic [1:0] {
    SDA_IDLE = 2'b00,
    SDA_ACK  = 2'b01,
    SDA_NACK = 2'b10,
    SDA_TX   = 2'b11
  } sda_mode_t;

  typedef enum logic [3:0] {
    IDLE,
    RX_ADDR,
    ADDR_CHK,
    ACK_ADDR,
    NACK_ADDR,
    LOAD,
    TX_BYTE,
    ACK_WAIT,
    ACK_CHK,
    ACK_END,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/i2c_slave_ctrl.sv
// Sequencing FSM for the read-only I2C slave: address check,
// ACK/NACK drive, TX FIFO pops and per-transaction byte count.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_found,
  input  logic             stop_found,
  input  logic             byte_received,
  input  logic [7:0]       rx_data,
  input  logic             ack_prep,
  input  logic             check_ack,
  input  logic             ack_done,
  input  logic             sda_in,
  input  logic             fifo_empty,
  output logic             rx_enable,
  output logic             tx_enable,
  output logic             load_data,
  output logic             read_enable,
  output sda_mode_t        sda_mode,
  output logic             underrun,
  output logic [CNT_W-1:0] tx_count
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cont_q, cont_d;
  logic             slot_q, slot_d;
  logic             match;

  assign match = (rx_data[7:1] == SLAVE_ADDR) && rx_data[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: ;
      RX_ADDR: begin
        if (byte_received) state_d = ADDR_CHK;
      end
      ADDR_CHK: begin
        slot_d  = 1'b0;
        state_d = match ? ACK_ADDR : NACK_ADDR;
      end
      ACK_ADDR, NACK_ADDR: begin
        // slot_q marks that the ACK slot is open on the bus
        if (ack_prep) slot_d = 1'b1;
        if (slot_q && ack_done) begin
          slot_d  = 1'b0;
          state_d = (state_q == ACK_ADDR) ? LOAD : HOLD;
        end
      end
      LOAD: state_d = TX_BYTE;
      TX_BYTE: begin
        if (ack_prep) state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (check_ack) state_d = ACK_CHK;
      end
      ACK_CHK: begin
        cont_d  = ~sda_in;
        state_d = ACK_END;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      ACK_END: begin
        if (ack_done) state_d = cont_q ? LOAD : HOLD;
      end
      HOLD: ;
      default: state_d = IDLE;
    endcase
    if (stop_found) begin
      state_d = IDLE;
      slot_d  = 1'b0;
    end else if (start_found) begin
      state_d = RX_ADDR;
      cnt_d   = '0;
      slot_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      slot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    load_data   = 1'b0;
    read_enable = 1'b0;
    underrun    = 1'b0;
    sda_mode    = SDA_IDLE;
    unique case (state_q)
      RX_ADDR: rx_enable = 1'b1;
      ACK_ADDR: begin
        if (slot_q) sda_mode = SDA_ACK;
      end
      NACK_ADDR: begin
        if (slot_q) sda_mode = SDA_NACK;
      end
      LOAD: begin
        // a load from an empty FIFO resends the stale head
        load_data   = 1'b1;
        read_enable = ~fifo_empty;
        underrun    = fifo_empty;
      end
      TX_BYTE: begin
        tx_enable = 1'b1;
        sda_mode  = SDA_TX;
      end
      default: ;
    endcase
  end

  assign tx_count = cnt_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed self-checking bench for i2c_slave_ctrl.
// Inputs change on the falling edge; outputs are checked there too.
module tb_i2c_slave_ctrl;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_found, stop_found, byte_received;
  logic [7:0] rx_data;
  logic       ack_prep, check_ack, ack_done;
  logic       sda_in, fifo_empty;
  logic       rx_enable, tx_enable, load_data, read_enable, underrun;
  sda_mode_t  sda_mode;
  logic [7:0] tx_count;

  int checks = 0;
  int failures = 0;

  i2c_slave_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start_found  (start_found),
    .stop_found   (stop_found),
    .byte_received(byte_received),
    .rx_data      (rx_data),
    .ack_prep     (ack_prep),
    .check_ack    (check_ack),
    .ack_done     (ack_done),
    .sda_in       (sda_in),
    .fifo_empty   (fifo_empty),
    .rx_enable    (rx_enable),
    .tx_enable    (tx_enable),
    .load_data    (load_data),
    .read_enable  (read_enable),
    .sda_mode     (sda_mode),
    .underrun     (underrun),
    .tx_count     (tx_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ck(input string tag, input logic [7:0] got,
                    input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic p_start();
    start_found = 1'b1; tick(); start_found = 1'b0;
  endtask

  task automatic p_stop();
    stop_found = 1'b1; tick(); stop_found = 1'b0;
  endtask

  task automatic p_prep();
    ack_prep = 1'b1; tick(); ack_prep = 1'b0;
  endtask

  task automatic p_done();
    ack_done = 1'b1; tick(); ack_done = 1'b0;
  endtask

  task automatic addr(input logic [7:0] a);
    rx_data = a;
    byte_received = 1'b1; tick(); byte_received = 1'b0;
    tick();
  endtask

  // From TX_BYTE: ACK slot with master response m, ends at ack_done
  task automatic tx_slot(input logic m);
    p_prep();
    sda_in = m;
    check_ack = 1'b1; tick(); check_ack = 1'b0;
    tick();
    p_done();
    sda_in = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    start_found = 0; stop_found = 0; byte_received = 0;
    rx_data = 8'h00; ack_prep = 0; check_ack = 0; ack_done = 0;
    sda_in = 1'b1; fifo_empty = 1'b0;
    tick(); tick();
    ck("rst_sda", sda_mode, 8'h0);
    ck("rst_rxen", rx_enable, 8'h0);
    ck("rst_cnt", tx_count, 8'h0);
    ck("rst_load", load_data, 8'h0);
    n_rst = 1'b1;
    tick();

    // valid read address, ACK then first load
    p_start();
    ck("s2_rxen", rx_enable, 8'h1);
    ck("s2_cnt", tx_count, 8'h0);
    rx_data = 8'hF1;
    byte_received = 1'b1; tick(); byte_received = 1'b0;
    ck("s2_chk_rxen", rx_enable, 8'h0);
    tick();
    ck("s2_pre_prep", sda_mode, 8'h0);
    p_prep();
    ck("s2_ack", sda_mode, 8'h1);
    tick();
    ck("s2_ack_hold", sda_mode, 8'h1);
    p_done();
    ck("s2_load", load_data, 8'h1);
    ck("s2_rden", read_enable, 8'h1);
    ck("s2_unrun", underrun, 8'h0);
    tick();
    ck("s2_load_off", load_data, 8'h0);
    ck("s2_txen", tx_enable, 8'h1);
    ck("s2_tx_sda", sda_mode, 8'h3);

    // repeated start during TX_BYTE
    p_start();
    ck("s5_rxen", rx_enable, 8'h1);
    ck("s5_txen", tx_enable, 8'h0);
    ck("s5_cnt", tx_count, 8'h0);
    ck("s5_sda", sda_mode, 8'h0);

    // write address -> NACK, HOLD until STOP
    addr(8'hF0);
    p_prep();
    ck("s3w_nack", sda_mode, 8'h2);
    p_done();
    ck("s3w_load", load_data, 8'h0);
    ck("s3w_sda", sda_mode, 8'h0);
    tick(); tick();
    ck("s3w_hold_load", load_data, 8'h0);
    ck("s3w_hold_rx", rx_enable, 8'h0);
    p_stop();

    p_start();
    addr(8'hA1);
    p_prep();
    ck("s3a_nack", sda_mode, 8'h2);
    p_done();
    ck("s3a_load", load_data, 8'h0);
    p_stop();

    // two FIFO bytes, ACK, ACK, NACK
    p_start();
    addr(8'hF1);
    p_prep();
    p_done();
    ck("s4_l1", load_data, 8'h1);
    ck("s4_r1", read_enable, 8'h1);
    tick();
    p_prep();
    ck("s4_rel_sda", sda_mode, 8'h0);
    ck("s4_rel_tx", tx_enable, 8'h0);
    sda_in = 1'b0;
    check_ack = 1'b1; tick(); check_ack = 1'b0;
    tick();
    ck("s4_cnt1", tx_count, 8'h1);
    p_done();
    sda_in = 1'b1;
    ck("s4_l2", load_data, 8'h1);
    ck("s4_r2", read_enable, 8'h1);
    ck("s4_u2", underrun, 8'h0);
    tick();
    fifo_empty = 1'b1;
    tx_slot(1'b0);
    ck("s4_l3", load_data, 8'h1);
    ck("s4_r3", read_enable, 8'h0);
    ck("s4_u3", underrun, 8'h1);
    ck("s4_cnt2", tx_count, 8'h2);
    tick();
    tx_slot(1'b1);
    ck("s4_noload", load_data, 8'h0);
    ck("s4_cnt3", tx_count, 8'h3);
    tick();
    ck("s4_hold_sda", sda_mode, 8'h0);
    ck("s4_hold_tx", tx_enable, 8'h0);
    p_stop();
    fifo_empty = 1'b0;

    // async reset in TX_BYTE with a nonzero count
    p_start();
    addr(8'hF1);
    p_prep();
    p_done();
    tick();
    tx_slot(1'b0);
    tick();
    ck("s1_pre_tx", tx_enable, 8'h1);
    ck("s1_pre_cnt", tx_count, 8'h1);
    #2 n_rst = 1'b0;
    #1;
    ck("s1_sda", sda_mode, 8'h0);
    ck("s1_txen", tx_enable, 8'h0);
    ck("s1_cnt", tx_count, 8'h0);
    tick();
    n_rst = 1'b1;
    tick();

    // start and stop together in TX_BYTE: stop wins
    p_start();
    addr(8'hF1);
    p_prep();
    p_done();
    tick();
    ck("s6_pre_tx", tx_enable, 8'h1);
    start_found = 1'b1; stop_found = 1'b1;
    tick();
    start_found = 1'b0; stop_found = 1'b0;
    ck("s6_rxen", rx_enable, 8'h0);
    ck("s6_txen", tx_enable, 8'h0);
    ck("s6_sda", sda_mode, 8'h0);
    ck("s6_load", load_data, 8'h0);
    rx_data = 8'hF1;
    byte_received = 1'b1; tick(); byte_received = 1'b0;
    tick();
    p_prep();
    ck("s6_idle_sda", sda_mode, 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
